csa_pipe_adder: RTL and testbench



---
 rtl/csa_pipe_adder_if.sv | 27 ++
 rtl/csa_pipe_adder.sv | 126 ++++++++++++
 tb/tb_csa_pipe_adder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/csa_pipe_adder_if.sv
// Operand/result handshake bundle for csa_pipe_adder.
// master: producer of operands and consumer of results; slave: the adder.
interface csa_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor.
// The capture stage computes every BLOCK-bit slice for both carry-in
// hypotheses; each following stage resolves one more slice using the carry
// resolved by the stage before it. Depth = WIDTH/BLOCK, one op per cycle.
module csa_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic           clk,
  input  logic           rst,
  csa_pipe_adder_if.slave bus
);
  localparam int NB = WIDTH / BLOCK;

  if (WIDTH % BLOCK != 0) begin : g_bad_cfg
    $error("csa_pipe_adder: WIDTH must be a multiple of BLOCK");
  end

  // Capture-stage combinational results
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c_eff;
  logic [WIDTH-1:0] w_s0;
  logic [WIDTH-1:0] w_s1;
  logic [NB-1:0]    w_c0;
  logic [NB-1:0]    w_c1;
  logic [WIDTH-1:0] w_res;
  logic             w_cr;
  logic             w_m0;
  logic             w_m1;
  logic             w_mr;
  logic             w_stall;

  // Per-stage state: index i holds the stage that has slices 0..i resolved
  logic [NB-1:0]    r_vld;
  logic [WIDTH-1:0] r_res [NB];
  logic [WIDTH-1:0] r_s0  [NB];
  logic [WIDTH-1:0] r_s1  [NB];
  logic [NB-1:0]    r_c0  [NB];
  logic [NB-1:0]    r_c1  [NB];
  logic [NB-1:0]    r_cr;
  logic             r_m0  [NB];
  logic             r_m1  [NB];
  logic             r_mr  [NB];

  // Stall only when a presented result is refused; never depends on in_valid
  assign w_stall      = r_vld[NB-1] && !bus.out_ready;
  assign bus.in_ready = !w_stall;

  // Operand prep and both-hypothesis slice sums; slice 0 resolved with c_eff
  always_comb begin
    w_b_eff = bus.sub ? ~bus.b : bus.b;
    w_c_eff = bus.sub | bus.cin;
    w_s0    = '0;
    w_s1    = '0;
    w_c0    = '0;
    w_c1    = '0;
    for (int j = 0; j < NB; j++) begin
      {w_c0[j], w_s0[j*BLOCK +: BLOCK]} = {1'b0, bus.a[j*BLOCK +: BLOCK]}
                                        + {1'b0, w_b_eff[j*BLOCK +: BLOCK]};
      {w_c1[j], w_s1[j*BLOCK +: BLOCK]} = {1'b0, bus.a[j*BLOCK +: BLOCK]}
                                        + {1'b0, w_b_eff[j*BLOCK +: BLOCK]}
                                        + {{BLOCK{1'b0}}, 1'b1};
    end
    w_res              = w_s0;
    w_res[BLOCK-1:0]   = w_c_eff ? w_s1[BLOCK-1:0] : w_s0[BLOCK-1:0];
    w_cr               = w_c_eff ? w_c1[0] : w_c0[0];
    // Carry into the MSB recovered from the MSB sum bit: s ^ a ^ b
    w_m0 = w_s0[WIDTH-1] ^ bus.a[WIDTH-1] ^ w_b_eff[WIDTH-1];
    w_m1 = w_s1[WIDTH-1] ^ bus.a[WIDTH-1] ^ w_b_eff[WIDTH-1];
    // Only meaningful when NB == 1; deeper pipes resolve it in the last stage
    w_mr = w_c_eff ? w_m1 : w_m0;
  end

  // Pipeline advance: capture into stage 0, resolve slice i in stage i
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_cr  <= '0;
      for (int i = 0; i < NB; i++) begin
        r_res[i] <= '0;
        r_s0[i]  <= '0;
        r_s1[i]  <= '0;
        r_c0[i]  <= '0;
        r_c1[i]  <= '0;
        r_m0[i]  <= 1'b0;
        r_m1[i]  <= 1'b0;
        r_mr[i]  <= 1'b0;
      end
    end else if (!w_stall) begin
      r_vld[0] <= bus.in_valid;
      r_res[0] <= w_res;
      r_s0[0]  <= w_s0;
      r_s1[0]  <= w_s1;
      r_c0[0]  <= w_c0;
      r_c1[0]  <= w_c1;
      r_cr[0]  <= w_cr;
      r_m0[0]  <= w_m0;
      r_m1[0]  <= w_m1;
      r_mr[0]  <= w_mr;
      for (int i = 1; i < NB; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_s0[i]  <= r_s0[i-1];
        r_s1[i]  <= r_s1[i-1];
        r_c0[i]  <= r_c0[i-1];
        r_c1[i]  <= r_c1[i-1];
        r_m0[i]  <= r_m0[i-1];
        r_m1[i]  <= r_m1[i-1];
        r_res[i] <= r_res[i-1];
        r_res[i][i*BLOCK +: BLOCK] <= r_cr[i-1] ? r_s1[i-1][i*BLOCK +: BLOCK]
                                                : r_s0[i-1][i*BLOCK +: BLOCK];
        r_cr[i]  <= r_cr[i-1] ? r_c1[i-1][i] : r_c0[i-1][i];
        if (i == NB - 1) begin
          r_mr[i] <= r_cr[i-1] ? r_m1[i-1] : r_m0[i-1];
        end else begin
          r_mr[i] <= r_mr[i-1];
        end
      end
    end
  end

  assign bus.out_valid = r_vld[NB-1];
  assign bus.sum       = r_res[NB-1];
  assign bus.cout      = r_cr[NB-1];
  assign bus.ovf       = r_mr[NB-1] ^ r_cr[NB-1];

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Scoreboard bench for csa_pipe_adder (WIDTH=16, BLOCK=4).
// Expected results are queued on acceptance; a negedge monitor pops and
// compares whenever a result is handed off.
module tb_csa_pipe_adder;
  localparam int W  = 16;
  localparam int B  = 4;
  localparam int NB = W / B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csa_pipe_adder_if #(.WIDTH(W)) bus ();

  csa_pipe_adder #(.WIDTH(W), .BLOCK(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [W+1:0] q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_pop    = 0;
  bit rdy_rand = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, {ovf, cout, sum}
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic ci, input logic sb);
    longint ua, ub, sa, sbv, ur, sr, lim;
    logic   co, ov;
    ua  = longint'(a);
    ub  = longint'(b);
    lim = longint'(1) << (W - 1);
    sa  = a[W-1] ? ua - 2 * lim : ua;
    sbv = b[W-1] ? ub - 2 * lim : ub;
    if (sb) begin
      ur = ua - ub;
      sr = sa - sbv;
      co = (ua >= ub);
    end else begin
      ur = ua + ub + longint'(ci);
      sr = sa + sbv + longint'(ci);
      co = (ur >= 2 * lim);
    end
    ov = (sr >= lim) || (sr < -lim);
    return {ov, co, ur[W-1:0]};
  endfunction

  // Present one operand set until accepted; queue its expected result
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic sb, input logic [W+1:0] exp);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.cin = ci;
    bus.sub = sb;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready && !rst) begin
        q.push_back(exp);
        done = 1;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!done) check("send_timeout", 64'(done), 64'd1);
  endtask

  task automatic drain(input int limit);
    for (int k = 0; k < limit && q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // Edges from acceptance until out_valid is seen (accept edge counts as 1)
  task automatic measure_latency(input string name);
    int lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check(name, 64'(lat), 64'(NB));
  endtask

  // Random consumer backpressure
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: handoff pops, stall hold, in_ready rule
  initial begin
    bit           prev_stall = 0;
    logic [W+1:0] prev_out   = '0;
    logic [W+1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        check("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
        if (prev_stall) begin
          check("hold_valid", 64'(bus.out_valid), 64'd1);
          check("hold_data", 64'({bus.ovf, bus.cout, bus.sum}), 64'(prev_out));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            check("spurious_out", 64'(bus.out_valid), 64'd0);
          end else begin
            e = q.pop_front();
            check("result", 64'({bus.ovf, bus.cout, bus.sum}), 64'(e));
            n_pop++;
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_out   = {bus.ovf, bus.cout, bus.sum};
      end
    end
  end

  initial begin
    int pops_before;
    logic [W-1:0] ra, rb;
    logic rc, rs;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_sum", 64'(bus.sum), 64'd0);
    check("reset_flags", 64'({bus.cout, bus.ovf}), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed arithmetic with known answers
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0100});
    measure_latency("latency_first");
    drain(20);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
    send(16'h7FFF, 16'h0000, 1'b1, 1'b0, {1'b1, 1'b0, 16'h8000});
    send(16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    send(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    drain(20);

    // Six back-to-back ops, consumer refuses for 3 cycles after first result
    pops_before = n_pop;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          ra = 16'(16'h1111 * (i + 1));
          rb = 16'(16'h0F0F + i);
          send(ra, rb, i[0], i[1], ref_model(ra, rb, i[0], i[1]));
        end
      end
      begin
        for (int k = 0; k < 20 && !bus.out_valid; k++) begin
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", 64'(bus.in_ready), 64'd0);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain(40);
    check("stall_count", 64'(n_pop - pops_before), 64'd6);

    // Reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      ra = 16'(16'h0123 << i);
      send(ra, 16'h0456, 1'b0, 1'b0, ref_model(ra, 16'h0456, 1'b0, 1'b0));
    end
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_flush_valid", 64'(bus.out_valid), 64'd0);
    check("rst_flush_sum", 64'(bus.sum), 64'd0);
    repeat (6) begin
      @(negedge clk);
      check("rst_no_stale", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send(16'h1234, 16'h4321, 1'b1, 1'b0, {1'b0, 1'b0, 16'h5556});
    measure_latency("latency_after_rst");
    drain(20);

    // Randomized traffic with random gaps and backpressure
    rdy_rand = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      case ($urandom_range(0, 7))
        0:       ra = '1;
        1:       ra = 16'h8000;
        2:       ra = 16'h7FFF;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       rb = '1;
        1:       rb = '0;
        2:       rb = 16'h8000;
        default: rb = 16'($urandom);
      endcase
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rc, rs, ref_model(ra, rb, rc, rs));
    end
    drain(400);
    rdy_rand = 0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
